bist_scheduler: RTL and testbench
=================================

# bist_scheduler

Arbitration and sequencing front-end for the BIST controller. Shares one BIST controller/MISR datapath between up to NREQ requesters (host, power-on self-test, debug, …) using round-robin grant. For each granted request it resets the controller, pulses start and waits for bist_end with a timeout. It then samples the signature-compare result and returns a one-cycle done/pass report to the granted requester.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 1023: maximum cycles to wait for bist_end after start; must be ≥ controller NCLOCK + 8.
- TW, $clog2(TIMEOUT+1): timeout counter width (derived, do not override).
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req  in  NREQ  level request per requester; held until its done pulse.
- grant  out  NREQ  one-hot, owner of the BIST datapath; all-zero when idle.
- sel  out  $clog2(NREQ)  binary index of current grant; 0 when idle.
- ctl_reset  out  1  synchronous active-high reset pulse to the BIST controller.
- ctl_start  out  1  start pulse to the BIST controller.
- bist_end  in  1  controller completion flag (cleared by controller on start/reset).
- sig_ok  in  1  signature-compare result, valid while bist_end=1.
- done  out  1  one-cycle pulse, result for requester sel.
- pass  out  1  valid with done: 1 = sig_ok sampled high and no timeout.
- timeout_err  out  1  valid with done: bist_end never rose within TIMEOUT.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ARB, CRST, START, WLOW, WEND, REPORT.
- IDLE: when |req → ARB; else stay.
- ARB: round-robin pick. Search starts at index ptr+1 mod NREQ; the first set req wins. grant/sel are registered on the ARB→CRST transition, and ptr ← winner. If req dropped to 0 → IDLE, no grant.
- CRST: ctl_reset=1 for exactly 1 cycle → START. ctl_reset and ctl_start are never high in the same cycle.
- START: ctl_start=1 for exactly 1 cycle; timeout counter cleared → WLOW.
- WLOW: wait for bist_end=0, so a stale flag from the previous session is ignored. When bist_end=0 → WEND. The counter runs in WLOW and WEND.
- WEND: when bist_end=1 → REPORT with pass_r ← sig_ok, to_r ← 0. When counter == TIMEOUT → REPORT with pass_r ← 0, to_r ← 1. If both happen in the same cycle, bist_end wins.
- REPORT: done=1, pass=pass_r, timeout_err=to_r for 1 cycle. Then grant ← 0 and sel ← 0, → IDLE. IDLE re-enters ARB the next cycle if any req is still high.
- pass and timeout_err are 0 whenever done=0.
- A requester deasserting req after grant does not abort the session. The session completes and done is still issued.
- Requests arriving during a session wait. Round-robin guarantees each active requester is served within NREQ sessions.
- Timeout counter: TW bits, saturates at TIMEOUT, never wraps.

## Timing
- Reset (reset=0, async): state=IDLE, ptr=NREQ-1 (requester 0 has first priority), counter=0. All outputs are 0: grant, sel, ctl_reset, ctl_start, done, pass, timeout_err, busy. Deassertion is synchronised internally, with 2-flop release.
- Reset mid-session: outputs drop to 0 immediately. No done is issued for the aborted session. After release, the scheduler restarts from IDLE with requester 0 first.
- Latency, req rising in IDLE:
  - cycle 1: ARB;
  - cycle 2: CRST (grant visible, ctl_reset=1);
  - cycle 3: ctl_start=1;
  - cycle 4: earliest WLOW.
- done follows bist_end rising by exactly 1 cycle: bist_end is sampled in WEND, and done is registered in REPORT.
- Minimum gap between consecutive sessions: 2 cycles (REPORT→IDLE→ARB).
- busy is high from ARB through REPORT inclusive.

## Test plan
- Single session: req=4'b0001; model asserts bist_end with sig_ok=1 650 cycles after ctl_start.
  - grant=0001 two cycles after req.
  - ctl_reset and ctl_start are one cycle each, consecutive.
  - done=1, pass=1, timeout_err=0 one cycle after bist_end.
- Round-robin: req=4'b1111 held → grant order 0001, 0010, 0100, 1000, 0001. Each grant is preceded by its own ctl_reset/ctl_start pair.
- Fail: sig_ok=0 at bist_end → done=1, pass=0, timeout_err=0.
- Timeout: bist_end never rises → done TIMEOUT+1 cycles after the cycle following ctl_start, with pass=0 and timeout_err=1. The next requester is then granted.
- Stale flag: bist_end held 1 through START, falls 3 cycles later, rises again at 650 → no early done; done follows the second rise.
- Reset mid-WEND: reset=0 for 2 cycles → all outputs 0 asynchronously, no done. With req=4'b0110 after release, requester 1 is granted first.

Source files
------------

// File: rtl/bist_scheduler_if.sv
// Signal bundle between the BIST scheduler and its requesters / BIST controller.
// req is a level request held until done; done is a one-cycle valid qualifying pass and timeout_err.
interface bist_scheduler_if #(
    parameter int NREQ = 4
);
    localparam int SW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [SW-1:0]   sel;
    logic            ctl_reset;
    logic            ctl_start;
    logic            bist_end;
    logic            sig_ok;
    logic            done;
    logic            pass;
    logic            timeout_err;
    logic            busy;
    logic [2:0]      dbg_state;

    modport master (
        input  req, bist_end, sig_ok,
        output grant, sel, ctl_reset, ctl_start, done, pass, timeout_err, busy, dbg_state
    );

    modport slave (
        output req, bist_end, sig_ok,
        input  grant, sel, ctl_reset, ctl_start, done, pass, timeout_err, busy, dbg_state
    );
endinterface

// File: rtl/bist_scheduler.sv
// Round-robin arbiter and session sequencer sharing one BIST controller between NREQ requesters.
// Each session: controller reset, start pulse, wait for bist_end (with timeout), one-cycle report.
module bist_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    bist_scheduler_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(NREQ);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARB    = 3'd1;
    localparam logic [2:0] S_CRST   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_WLOW   = 3'd4;
    localparam logic [2:0] S_WEND   = 3'd5;
    localparam logic [2:0] S_REPORT = 3'd6;

    localparam logic [TW-1:0]   CNT_MAX  = TW'(TIMEOUT);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    // Reset asserts asynchronously, releases two clocks after the pin rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    logic [2:0]      state_q, state_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            pass_q, pass_d;
    logic            to_q, to_d;

    logic            win_found;
    logic [SW-1:0]   win_idx;
    int              arb_idx;

    // Search starts one past the last winner, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        arb_idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            arb_idx = int'(ptr_q) + i;
            if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
            if (!win_found && bus.req[arb_idx[SW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = arb_idx[SW-1:0];
            end
        end
    end

    logic cnt_at_max;
    assign cnt_at_max = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        pass_d  = pass_q;
        to_d    = to_q;

        if ((state_q == S_WLOW || state_q == S_WEND) && !cnt_at_max)
            cnt_d = cnt_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                if (|bus.req) state_d = S_ARB;
            end
            S_ARB: begin
                if (win_found) begin
                    grant_d = ONE_HOT0 << win_idx;
                    sel_d   = win_idx;
                    ptr_d   = win_idx;
                    state_d = S_CRST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CRST: state_d = S_START;
            S_START: begin
                cnt_d   = '0;
                state_d = S_WLOW;
            end
            S_WLOW: begin
                // A flag stuck high would otherwise hold the datapath forever.
                if (!bus.bist_end) begin
                    state_d = S_WEND;
                end else if (cnt_at_max) begin
                    pass_d  = 1'b0;
                    to_d    = 1'b1;
                    state_d = S_REPORT;
                end
            end
            S_WEND: begin
                if (bus.bist_end) begin
                    pass_d  = bus.sig_ok;
                    to_d    = 1'b0;
                    state_d = S_REPORT;
                end else if (cnt_at_max) begin
                    pass_d  = 1'b0;
                    to_d    = 1'b1;
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                grant_d = '0;
                sel_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= SW'(NREQ - 1);
            cnt_q   <= '0;
            grant_q <= '0;
            sel_q   <= '0;
            pass_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            pass_q  <= pass_d;
            to_q    <= to_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.sel         = sel_q;
    assign bus.ctl_reset   = (state_q == S_CRST);
    assign bus.ctl_start   = (state_q == S_START);
    assign bus.done        = (state_q == S_REPORT);
    assign bus.pass        = (state_q == S_REPORT) && pass_q;
    assign bus.timeout_err = (state_q == S_REPORT) && to_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_bist_scheduler.sv
// Bench for bist_scheduler: behavioural BIST controller, round-robin reference model and
// an expected-result queue consumed whenever done is presented.
module tb_bist_scheduler;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 1023;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bist_scheduler_if #(.NREQ(NREQ)) bus ();

    bist_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int dly;
        bit sig;
        bit stale;
    } beh_t;

    beh_t        beh_q[$];
    logic [33:0] exp_q[$];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    bit stall_flag = 0;
    bit stall_seen = 0;
    bit end_req = 0;
    bit end_ack = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic int rr_pick(logic [NREQ-1:0] r, int p);
        for (int i = 1; i <= NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    // Monitor, reference model and BIST controller model share one process.
    int              mptr = NREQ - 1;
    int              cur_w = 0;
    bit              lat_arm = 0;
    int              lat_cyc = 0;
    logic [NREQ-1:0] prev_req = '0;
    bit              prev_crst = 0;
    bit              c_act = 0;
    int              c_cs = 0;
    beh_t            c_beh;

    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_outputs", int'({bus.grant, bus.sel, bus.ctl_reset, bus.ctl_start,
                                       bus.done, bus.pass, bus.timeout_err, bus.busy}), 0);
            exp_q.delete();
            c_act = 0;
            mptr = NREQ - 1;
            lat_arm = 0;
            prev_crst = 0;
            bus.bist_end = 1'b0;
        end else begin
            if (bus.req != '0 && prev_req == '0 && !bus.busy) begin
                lat_arm = 1;
                lat_cyc = cyc;
            end
            if (bus.ctl_reset) begin
                int w;
                w = rr_pick(bus.req, mptr);
                chk("ctl_overlap", int'(bus.ctl_start), 0);
                chk("grant", int'(bus.grant), (w < 0) ? 0 : (1 << w));
                chk("sel", int'(bus.sel), (w < 0) ? 0 : w);
                chk("busy_in_session", int'(bus.busy), 1);
                if (lat_arm) chk("grant_latency", cyc - lat_cyc, 2);
                lat_arm = 0;
                if (w >= 0) begin
                    cur_w = w;
                    mptr = w;
                end
            end
            if (bus.ctl_start) chk("start_after_reset", int'(prev_crst), 1);
            if (bus.done) begin
                chk("done_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    chk("pass", int'(bus.pass), int'(e[0]));
                    chk("timeout_err", int'(bus.timeout_err), int'(e[1]));
                    chk("done_cycle", cyc, int'(e[33:2]));
                    chk("done_sel", int'(bus.sel), cur_w);
                    chk("done_grant", int'(bus.grant), 1 << cur_w);
                end
                done_cnt++;
            end else begin
                chk("quiet_flags", int'({bus.pass, bus.timeout_err}), 0);
            end
            prev_crst = bus.ctl_reset;

            if (!bus.bist_end) bus.sig_ok = 1'($urandom_range(0, 1));
            if (bus.ctl_start) begin
                if (beh_q.size() > 0) c_beh = beh_q.pop_front();
                else begin
                    c_beh.dly = 100;
                    c_beh.sig = 1;
                    c_beh.stale = 0;
                end
                c_act = 1;
                c_cs = cyc;
                if (!c_beh.stale) bus.bist_end = 1'b0;
                if (c_beh.dly == 0) exp_q.push_back({32'(cyc + TIMEOUT + 2), 1'b1, 1'b0});
            end else if (c_act) begin
                if (c_beh.stale && cyc == c_cs + 3) bus.bist_end = 1'b0;
                if (c_beh.dly != 0 && cyc == c_cs + c_beh.dly) begin
                    bus.bist_end = 1'b1;
                    bus.sig_ok = c_beh.sig;
                    exp_q.push_back({32'(cyc + 1), 1'b0, c_beh.sig});
                    c_act = 0;
                end
            end
        end
        if (stall_flag && !stall_seen) begin
            stall_seen = 1;
            chk("wait_bound", int'(stall_flag), 0);
        end
        if (end_req && !end_ack) begin
            chk("queue_drained", exp_q.size(), 0);
            end_ack = 1;
        end
        prev_req = bus.req;
    end

    task automatic push_beh(int d, bit s, bit st);
        beh_t b;
        b.dly = d;
        b.sig = s;
        b.stale = st;
        beh_q.push_back(b);
    endtask

    task automatic wait_for(int target, int n);
        for (int k = 0; k < n * (TIMEOUT + 800); k++) begin
            if (done_cnt >= target) return;
            @(posedge clk);
            #1;
        end
        stall_flag = 1;
    endtask

    task automatic session(logic [NREQ-1:0] r, int n);
        int t;
        t = done_cnt;
        bus.req = r;
        wait_for(t + n, n);
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.req = '0;
        bus.bist_end = 1'b0;
        bus.sig_ok = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(4);

        push_beh(650, 1, 0);
        session(4'b0001, 1);
        bus.req = '0;
        idle(3);

        push_beh(300, 0, 0);
        session(4'b0010, 1);
        bus.req = '0;
        idle(3);

        push_beh(0, 0, 0);
        push_beh(200, 1, 0);
        session(4'b0101, 2);
        bus.req = '0;
        idle(3);

        push_beh(650, 1, 1);
        session(4'b1000, 1);
        bus.req = '0;
        idle(3);

        for (int i = 0; i < 5; i++) push_beh($urandom_range(20, 700), 1'($urandom_range(0, 1)), 0);
        session(4'b1111, 5);
        bus.req = '0;
        idle(3);

        for (int i = 0; i < 8; i++) begin
            int d;
            d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(20, 700);
            push_beh(d, 1'($urandom_range(0, 1)), 0);
            session(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1);
        end
        bus.req = '0;
        idle(3);

        push_beh(0, 0, 0);
        bus.req = 4'b0001;
        idle(100);
        reset = 1'b0;
        bus.req = '0;
        idle(2);
        reset = 1'b1;
        idle(4);
        push_beh($urandom_range(20, 700), 1, 0);
        push_beh($urandom_range(20, 700), 1'($urandom_range(0, 1)), 0);
        session(4'b0110, 2);
        bus.req = '0;
        idle(5);

        end_req = 1;
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
